fifo_fwft: RTL and testbench

Parametrised successor to the team's valid/consent FIFO. Adds first-word-fall-through output, a SKID allowance for the writer, almost-full/almost-empty flags, a fill level, synchronous flush and a sticky overflow flag. Sits between streaming FFT stages, e.g. butterfly output to reorder buffer, on a single clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/dp_ram.sv | 42 ++++
 rtl/fifo_fwft.sv | 238 +++++++++++++++++++++++
 tb/tb_fifo_fwft.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the first-word-fall-through FIFO family.
//   addrWidth(depth)      : RAM address width for a given power-of-two depth.
//   level_wide_t          : wide unsigned type used to compare fill levels
//                           against integer thresholds without truncation.
//   DEFAULT_AFULL_MARGIN  : default distance of the almost-full threshold
//                           below capacity.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DEFAULT_AFULL_MARGIN = 4;
    localparam int unsigned LEVEL_CALC_WIDTH     = 32;

    typedef logic [LEVEL_CALC_WIDTH-1:0] level_wide_t;

    function automatic int unsigned addrWidth(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dp_ram.sv
// -----------------------------------------------------------------------------
// dp_ram
// Simple dual-port RAM: one write port, one synchronous read port, one clock.
// A read of an address written on the same edge returns the old contents;
// callers must not rely on write-through.
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data holds its value while low
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module dp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array and its read register carry no reset so the tools can
    // map them onto block RAM; validity is tracked by the caller's flags.
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_fwft.sv
// -----------------------------------------------------------------------------
// fifo_fwft
// Single-clock first-word-fall-through FIFO with writer skid allowance,
// almost-full/almost-empty flags, fill level, synchronous flush and a sticky
// overflow flag. Storage is a dp_ram followed by a prefetch stage (the RAM read
// register) and an output register, so an empty FIFO shows a word two edges
// after it is accepted and sustains one write plus one pop per cycle.
//
// Optional feature (macro FIFO_PEAK_EN): adds peakClrIn / peakOut, the
// registered maximum level since reset, flush or peakClrIn.
//
// Ports:
//   clkIn           in   clock, rising edge
//   rstNIn          in   asynchronous active-low reset
//   flushIn         in   synchronous clear, beats write and pop
//   wrValidIn       in   write request (accepted while level < DEPTH)
//   wrConsentOut    out  registered: next level < DEPTH-SKID
//   wrDataIn        in   write data
//   rdValidOut      out  rdDataOut holds the head word
//   rdConsentIn     in   reader takes the head word
//   rdDataOut       out  registered head word
//   levelOut        out  accepted words not yet popped
//   almostFullOut   out  level >= AFULL_LVL
//   almostEmptyOut  out  level <= AEMPTY_LVL
//   overflowOut     out  sticky: a write was dropped
//   peakClrIn       in   (FIFO_PEAK_EN) restart peak tracking
//   peakOut         out  (FIFO_PEAK_EN) peak level
// -----------------------------------------------------------------------------
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned SKID       = 0,
    parameter int unsigned AFULL_LVL  = DEPTH - DEFAULT_AFULL_MARGIN,
    parameter int unsigned AEMPTY_LVL = 2,
    localparam int unsigned ADDR_W    = addrWidth(DEPTH),
    localparam int unsigned LEVEL_W   = ADDR_W + 1
) (
    input  logic                  clkIn,
    input  logic                  rstNIn,
    input  logic                  flushIn,
    input  logic                  wrValidIn,
    output logic                  wrConsentOut,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    output logic                  rdValidOut,
    input  logic                  rdConsentIn,
    output logic [DATA_WIDTH-1:0] rdDataOut,
    output logic [LEVEL_W-1:0]    levelOut,
    output logic                  almostFullOut,
    output logic                  almostEmptyOut,
    output logic                  overflowOut
`ifdef FIFO_PEAK_EN
    ,
    input  logic                  peakClrIn,
    output logic [LEVEL_W-1:0]    peakOut
`endif
);

    localparam logic [LEVEL_W-1:0] DEPTH_L     = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] CONSENT_LIM = LEVEL_W'(DEPTH - SKID);
    localparam logic [LEVEL_W-1:0] ONE_L       = LEVEL_W'(1);
    localparam logic [ADDR_W-1:0]  ONE_A       = ADDR_W'(1);

    // Pointers and counts
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    ram_cnt_q, ram_cnt_d;   // written to RAM, not yet read
    logic [LEVEL_W-1:0]    level_q, level_d;       // all words held, every stage

    // Pipeline stages after the RAM
    logic                  pf_valid_q, pf_valid_d; // RAM read register is live
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Registered flags
    logic                  consent_q, consent_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;

    // Per-cycle events
    logic                  wr_accept;
    logic                  wr_drop;
    logic                  pop;
    logic                  out_load;
    logic                  rd_issue;
    logic                  ram_wr_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_ram (
        .clk     (clkIn),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wrDataIn),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        level_d     = level_q;
        pf_valid_d  = pf_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        // Acceptance depends only on level; wrConsentOut is advisory.
        wr_accept = wrValidIn & (level_q < DEPTH_L);
        wr_drop   = wrValidIn & ~wr_accept;
        pop       = out_valid_q & rdConsentIn;
        // Prefetch moves into the output stage when that stage frees up.
        out_load  = pf_valid_q & (~out_valid_q | pop);
        // ram_cnt_q only counts words written on earlier edges, so the read
        // pointer never reaches an address being written this cycle.
        rd_issue  = (ram_cnt_q != '0) & (~pf_valid_q | out_load) & ~flushIn;
        ram_wr_en = wr_accept & ~flushIn;

        if (flushIn) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            level_d     = '0;
            pf_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            ovf_d       = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ONE_A;
            end
            if (rd_issue) begin
                rd_ptr_d = rd_ptr_q + ONE_A;
            end

            unique case ({wr_accept, rd_issue})
                2'b10:   ram_cnt_d = ram_cnt_q + ONE_L;
                2'b01:   ram_cnt_d = ram_cnt_q - ONE_L;
                default: ram_cnt_d = ram_cnt_q;
            endcase

            unique case ({wr_accept, pop})
                2'b10:   level_d = level_q + ONE_L;
                2'b01:   level_d = level_q - ONE_L;
                default: level_d = level_q;
            endcase

            if (rd_issue) begin
                pf_valid_d = 1'b1;
            end else if (out_load) begin
                pf_valid_d = 1'b0;
            end

            if (out_load) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_rd_data;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end

            ovf_d = ovf_q | wr_drop;
        end

        // Flags are registered copies of functions of the new level.
        consent_d = level_d < CONSENT_LIM;
        afull_d   = level_wide_t'(level_d) >= level_wide_t'(AFULL_LVL);
        aempty_d  = level_wide_t'(level_d) <= level_wide_t'(AEMPTY_LVL);
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            level_q     <= '0;
            pf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            consent_q   <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            level_q     <= level_d;
            pf_valid_q  <= pf_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            consent_q   <= consent_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wrConsentOut   = consent_q;
    assign rdValidOut     = out_valid_q;
    assign rdDataOut      = out_data_q;
    assign levelOut       = level_q;
    assign almostFullOut  = afull_q;
    assign almostEmptyOut = aempty_q;
    assign overflowOut    = ovf_q;

`ifdef FIFO_PEAK_EN
    logic [LEVEL_W-1:0] peak_q, peak_d;

    // A clear (or flush) restarts tracking from the level after this edge.
    always_comb begin
        peak_d = peak_q;
        if (flushIn || peakClrIn) begin
            peak_d = level_d;
        end else if (level_d > peak_q) begin
            peak_d = level_d;
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peakOut = peak_q;
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_fifo_fwft
// Scoreboard bench for fifo_fwft (DEPTH=16, SKID=2, AFULL_LVL=12,
// AEMPTY_LVL=2). The reference model is a queue of accepted words, each tagged
// with the edge that accepted it; the head is visible once two edges have
// passed since its acceptance. Flags are derived from the queue size.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_fwft;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int SKID   = 2;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 2;
    localparam int LW     = 5;

    logic          clkIn = 1'b0;
    logic          rstNIn = 1'b0;
    logic          flushIn = 1'b0;
    logic          wrValidIn = 1'b0;
    logic [DW-1:0] wrDataIn = '0;
    logic          rdConsentIn = 1'b0;
    logic          wrConsentOut;
    logic          rdValidOut;
    logic [DW-1:0] rdDataOut;
    logic [LW-1:0] levelOut;
    logic          almostFullOut;
    logic          almostEmptyOut;
    logic          overflowOut;
`ifdef FIFO_PEAK_EN
    logic          peak_clr = 1'b0;
    logic [LW-1:0] peakOut;
    int            m_peak;
    int            new_sz;
`endif

    fifo_fwft #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SKID       (SKID),
        .AFULL_LVL  (AFULL),
        .AEMPTY_LVL (AEMPTY)
    ) dut (
        .clkIn          (clkIn),
        .rstNIn         (rstNIn),
        .flushIn        (flushIn),
        .wrValidIn      (wrValidIn),
        .wrConsentOut   (wrConsentOut),
        .wrDataIn       (wrDataIn),
        .rdValidOut     (rdValidOut),
        .rdConsentIn    (rdConsentIn),
        .rdDataOut      (rdDataOut),
        .levelOut       (levelOut),
        .almostFullOut  (almostFullOut),
        .almostEmptyOut (almostEmptyOut),
        .overflowOut    (overflowOut)
`ifdef FIFO_PEAK_EN
        ,
        .peakClrIn      (peak_clr),
        .peakOut        (peakOut)
`endif
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic [31:0] data;
        int          edge_no;
    } entry_t;

    entry_t exp_q[$];
    entry_t ent;
    int     m_edge;
    bit     m_live;
    bit     m_ovf;
    int     n_cmp;
    int     n_fail;
    int     sz;
    bit     exp_valid;
    bit     acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_edge = 0;
        m_live = 1'b0;
        m_ovf  = 1'b0;
`ifdef FIFO_PEAK_EN
        m_peak = 0;
`endif
    endtask

    // Monitor: on each falling edge compare the DUT against the model state
    // for the last rising edge, then advance the model across the next one
    // (inputs are stable from just after a rising edge until the next).
    always @(negedge clkIn) begin
        if (!rstNIn) begin
            model_reset();
        end else begin
            sz        = exp_q.size();
            exp_valid = (sz > 0) && (exp_q[0].edge_no <= m_edge - 2);
            check("rd_valid", rdValidOut, exp_valid);
            if (rdValidOut && exp_valid) begin
                check("rd_data", rdDataOut, exp_q[0].data);
            end
            check("level", levelOut, sz);
            check("almost_full", almostFullOut, sz >= AFULL);
            check("almost_empty", almostEmptyOut, sz <= AEMPTY);
            check("overflow", overflowOut, m_ovf);
            check("wr_consent", wrConsentOut, m_live && (sz < DEPTH - SKID));
`ifdef FIFO_PEAK_EN
            check("peak", peakOut, m_peak);
`endif
            if (flushIn) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else begin
                acc = wrValidIn && (sz < DEPTH);
                if (wrValidIn && !acc) m_ovf = 1'b1;
                if (exp_valid && rdConsentIn) void'(exp_q.pop_front());
                if (acc) begin
                    ent.data    = wrDataIn;
                    ent.edge_no = m_edge + 1;
                    exp_q.push_back(ent);
                end
            end
            m_edge++;
            m_live = 1'b1;
`ifdef FIFO_PEAK_EN
            new_sz = exp_q.size();
            if (flushIn || peak_clr) m_peak = new_sz;
            else if (new_sz > m_peak) m_peak = new_sz;
`endif
        end
    end

    // Drive one cycle of inputs, return just after the rising edge.
    task automatic drive(input bit wv, input logic [31:0] wd, input bit rc, input bit fl);
        wrValidIn   = wv;
        wrDataIn    = wd;
        rdConsentIn = rc;
        flushIn     = fl;
        @(posedge clkIn);
        #1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 48; c++) drive(1'b0, '0, 1'b1, 1'b0);
        check(name, levelOut, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned wp, rp;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_reset();

        // Reset release and first-edge consent
        repeat (3) @(posedge clkIn);
        #1;
        rstNIn = 1'b1;
        check("consent_before_edge", wrConsentOut, 0);
        check("aempty_reset", almostEmptyOut, 1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("consent_after_edge", wrConsentOut, 1);

        // Single write latency
        drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        check("lat_k_valid", rdValidOut, 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("lat_k1_valid", rdValidOut, 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("lat_k2_valid", rdValidOut, 1);
        check("lat_k2_data", rdDataOut, 32'hA5A5_0001);
        check("lat_k2_level", levelOut, 1);
        check("lat_k2_aempty", almostEmptyOut, 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("lat_pop_level", levelOut, 0);

        // Fill to capacity, overflow, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            check("fill_consent", wrConsentOut, (i + 1) < DEPTH - SKID);
            check("fill_afull", almostFullOut, (i + 1) >= AFULL);
        end
        check("full_level", levelOut, DEPTH);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("full_drop_level", levelOut, DEPTH);
        check("full_overflow", overflowOut, 1);
        drain("full_drain_level");
        check("overflow_sticky", overflowOut, 1);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("flush_clears_overflow", overflowOut, 0);

        // Streaming: prime three words, then write and pop every cycle
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            check("stream_level", levelOut, 3);
            check("stream_valid", rdValidOut, 1);
        end
        check("stream_overflow", overflowOut, 0);
        drain("stream_drain_level");

        // Flush with a same-cycle write
        for (int i = 0; i < 9; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        check("preflush_level", levelOut, 9);
        drive(1'b1, 32'h0000_F00D, 1'b1, 1'b1);
        check("flush_level", levelOut, 0);
        check("flush_valid", rdValidOut, 0);
        check("flush_overflow", overflowOut, 0);
        check("flush_consent", wrConsentOut, 1);
        check("flush_aempty", almostEmptyOut, 1);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("post_flush_k", rdValidOut, 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_k1", rdValidOut, 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_k2_valid", rdValidOut, 1);
        check("post_flush_k2_data", rdDataOut, 32'h1234_5678);

`ifdef FIFO_PEAK_EN
        // Peak tracking
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("peak_level", levelOut, 4);
        check("peak_max", peakOut, 10);
        peak_clr = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        peak_clr = 1'b0;
        check("peak_cleared", peakOut, 4);
`endif
        drain("pre_random_drain");

        // Randomised traffic in phases with varying write/read pressure
        for (int ph = 0; ph < 12; ph++) begin
            wp = $urandom_range(20, 95);
            rp = $urandom_range(20, 95);
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
                      $urandom_range(0, 199) == 0);
            end
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h500 + 32'(i), i > 2, 1'b0);
        #1;
        rstNIn = 1'b0;
        #1;
        check("async_rst_valid", rdValidOut, 0);
        check("async_rst_data", rdDataOut, 0);
        check("async_rst_level", levelOut, 0);
        check("async_rst_consent", wrConsentOut, 0);
        check("async_rst_afull", almostFullOut, 0);
        check("async_rst_aempty", almostEmptyOut, 1);
        check("async_rst_overflow", overflowOut, 0);
        wrValidIn   = 1'b0;
        rdConsentIn = 1'b0;
        @(posedge clkIn);
        #1;
        rstNIn = 1'b1;
        check("rst_release_consent", wrConsentOut, 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("rst_edge_consent", wrConsentOut, 1);

        // Short random tail after reset, then empty out
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0, 1'b0);
        end
        drain("final_drain_level");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
